// File: rtl/rxll_frame_fifo.sv
// Frame-aware receive link-layer FIFO with first-word fall-through, a stored-frame
// counter and an optional store-and-forward mode that hides and discards bad frames.
module rxll_frame_fifo #(
    parameter int C_WIDTH         = 36,
    parameter int C_EOF_BIT       = 34,
    parameter int C_ADDR_W        = 9,
    parameter int C_AFULL_OFFSET  = 16,
    parameter int C_AEMPTY_OFFSET = 256,
    parameter int C_STORE_FWD     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [C_WIDTH-1:0]  wr_di,
    input  logic                wr_en,
    input  logic                wr_abort,
    output logic                wr_full,
    output logic                wr_almost_full,
    output logic [C_ADDR_W:0]   wr_count,
    output logic                wr_err,
    output logic                wr_drop,
    output logic [C_WIDTH-1:0]  rd_do,
    input  logic                rd_en,
    output logic                rd_empty,
    output logic                rd_almost_empty,
    output logic [C_ADDR_W:0]   rd_count,
    output logic                rd_err,
    output logic [C_ADDR_W:0]   rd_frames,
    output logic                rd_eof_rdy
);

    localparam int DEPTH    = 1 << C_ADDR_W;
    localparam int AFULL_TH = DEPTH - C_AFULL_OFFSET;
    localparam bit SF       = (C_STORE_FWD != 0);

    typedef logic [C_ADDR_W:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [C_WIDTH-1:0] mem [DEPTH];

    ptr_t rd_ptr;
    ptr_t wr_ptr;
    ptr_t cm_ptr;
    logic bad;

    ptr_t rd_ptr_n;
    ptr_t wr_ptr_n;
    ptr_t cm_ptr_n;
    ptr_t frames_n;
    ptr_t wr_cnt_n;
    ptr_t rd_cnt_n;
    logic bad_n;
    logic mem_we;
    logic wr_err_n;
    logic wr_drop_n;
    logic rd_err_n;
    logic rd_acc;
    logic frame_inc;
    logic frame_dec;

    assign rd_do = mem[rd_ptr[C_ADDR_W-1:0]];

    // Write side: abort beats everything; a second overflow of an already-bad frame
    // releases its space so an over-long frame can always reach its EOF and be dropped.
    always_comb begin
        wr_ptr_n  = wr_ptr;
        cm_ptr_n  = cm_ptr;
        bad_n     = bad;
        mem_we    = 1'b0;
        wr_err_n  = 1'b0;
        wr_drop_n = 1'b0;
        frame_inc = 1'b0;
        if (SF && wr_abort) begin
            wr_ptr_n  = cm_ptr;
            bad_n     = 1'b0;
            wr_drop_n = (wr_ptr != cm_ptr) || wr_en;
        end else if (wr_en && wr_full) begin
            wr_err_n = 1'b1;
            if (SF) begin
                bad_n = 1'b1;
                if (bad) begin
                    wr_ptr_n = cm_ptr;
                end
            end
        end else if (wr_en) begin
            mem_we = 1'b1;
            if (SF && bad && wr_di[C_EOF_BIT]) begin
                wr_ptr_n  = cm_ptr;
                bad_n     = 1'b0;
                wr_drop_n = 1'b1;
            end else begin
                wr_ptr_n = wr_ptr + PTR_ONE;
                if (wr_di[C_EOF_BIT]) begin
                    frame_inc = 1'b1;
                    cm_ptr_n  = wr_ptr + PTR_ONE;
                end
            end
        end
        if (!SF) begin
            cm_ptr_n = wr_ptr_n;
        end
    end

    always_comb begin
        rd_acc    = rd_en && !rd_empty;
        rd_err_n  = rd_en && rd_empty;
        rd_ptr_n  = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
        frame_dec = rd_acc && rd_do[C_EOF_BIT];
        case ({frame_inc, frame_dec})
            2'b10:   frames_n = rd_frames + PTR_ONE;
            2'b01:   frames_n = rd_frames - PTR_ONE;
            default: frames_n = rd_frames;
        endcase
        wr_cnt_n = wr_ptr_n - rd_ptr_n;
        rd_cnt_n = cm_ptr_n - rd_ptr_n;
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_ptr[C_ADDR_W-1:0]] <= wr_di;
        end
    end

    // Status is registered from next-state values so it always matches the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            cm_ptr          <= '0;
            bad             <= 1'b0;
            wr_count        <= '0;
            rd_count        <= '0;
            rd_frames       <= '0;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_eof_rdy      <= 1'b0;
            wr_err          <= 1'b0;
            wr_drop         <= 1'b0;
            rd_err          <= 1'b0;
        end else begin
            rd_ptr          <= rd_ptr_n;
            wr_ptr          <= wr_ptr_n;
            cm_ptr          <= cm_ptr_n;
            bad             <= bad_n;
            wr_count        <= wr_cnt_n;
            rd_count        <= rd_cnt_n;
            rd_frames       <= frames_n;
            wr_full         <= (wr_ptr_n[C_ADDR_W] != rd_ptr_n[C_ADDR_W]) &&
                               (wr_ptr_n[C_ADDR_W-1:0] == rd_ptr_n[C_ADDR_W-1:0]);
            wr_almost_full  <= (int'(wr_cnt_n) >= AFULL_TH);
            rd_empty        <= (rd_cnt_n == '0);
            rd_almost_empty <= (int'(rd_cnt_n) <= C_AEMPTY_OFFSET);
            rd_eof_rdy      <= (frames_n != '0);
            wr_err          <= wr_err_n;
            wr_drop         <= wr_drop_n;
            rd_err          <= rd_err_n;
        end
    end

endmodule

// File: doc/rxll_frame_fifo.md
# rxll_frame_fifo

Single-clock, parametrised, frame-aware receive link-layer FIFO with first-word fall-through. It sits between the SATA receive link layer and the transport/DMA consumer, and replaces the fixed 512x36 FIFO plus single EOF flag with:
- a configurable width and depth;
- a stored-frame counter;
- a store-and-forward mode that hides incomplete frames and can discard bad or aborted frames.

## Interface
- C_WIDTH, 36, entry width in bits (data plus sideband).
- C_EOF_BIT, 34, bit index within an entry marking the last word of a frame.
- C_ADDR_W, 9, log2 of depth; DEPTH = 2^C_ADDR_W.
- C_AFULL_OFFSET, 16, wr_almost_full asserts when wr_count >= DEPTH - C_AFULL_OFFSET.
- C_AEMPTY_OFFSET, 256, rd_almost_empty asserts when rd_count <= C_AEMPTY_OFFSET.
- C_STORE_FWD, 1, 1 = store-and-forward (only committed frames readable); 0 = cut-through.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_di  in  C_WIDTH  write data.
- wr_en  in  1  write request.
- wr_abort  in  1  discard the in-progress frame (store-and-forward only).
- wr_full  out  1  no free entry.
- wr_almost_full  out  1  see C_AFULL_OFFSET.
- wr_count  out  C_ADDR_W+1  occupied entries, committed plus uncommitted.
- wr_err  out  1  one-cycle pulse: write rejected because full.
- wr_drop  out  1  one-cycle pulse: an in-progress frame was discarded.
- rd_do  out  C_WIDTH  head entry; valid while rd_empty=0.
- rd_en  in  1  pop head entry.
- rd_empty  out  1  no readable entry.
- rd_almost_empty  out  1  see C_AEMPTY_OFFSET.
- rd_count  out  C_ADDR_W+1  readable entries.
- rd_err  out  1  one-cycle pulse: rd_en while empty.
- rd_frames  out  C_ADDR_W+1  complete frames stored and not fully read.
- rd_eof_rdy  out  1  rd_frames != 0.

## Operation
- Pointers: rd_ptr, wr_ptr (speculative) and cm_ptr (committed), each C_ADDR_W+1 bits with a wrap bit.
  - wr_count = wr_ptr - rd_ptr.
  - rd_count = cm_ptr - rd_ptr when C_STORE_FWD=1; otherwise wr_ptr - rd_ptr, with cm_ptr tracking wr_ptr.
- Write accepted iff wr_en & !wr_full, evaluated on current-cycle state. A concurrent rd_en does not free space in the same cycle.
- Rejected write: entry dropped, wr_err pulses.
  - C_STORE_FWD=1: the in-progress frame is marked bad.
- Accepted write with wr_di[C_EOF_BIT]=1 ends the frame.
  - Good frame: cm_ptr <= wr_ptr+1, and rd_frames increments.
  - Bad frame: wr_ptr <= cm_ptr (rewind), wr_drop pulses, bad flag clears, rd_frames unchanged.
- wr_abort (C_STORE_FWD=1): wr_ptr <= cm_ptr and bad flag clears. Any wr_en in the same cycle is discarded. wr_drop pulses only if at least one uncommitted word was discarded, or a word was presented that cycle.
- wr_abort (C_STORE_FWD=0): ignored.
- Read accepted iff rd_en & !rd_empty; rd_ptr increments. If the popped entry has the EOF bit set, rd_frames decrements.
- Simultaneous rd_frames increment and decrement: value unchanged.
- Cut-through: rd_frames counts EOF words written minus EOF words read.

## Timing
- Reset values: rd_empty=1, wr_full=0, wr_almost_full=0, rd_almost_empty=1, all counts 0, rd_frames=0, rd_eof_rdy=0, wr_err=wr_drop=rd_err=0, rd_do don't-care. Pointers and bad flag clear.
- rst mid-frame: all contents, including committed frames, are lost; no wr_drop pulse.
- Write-to-read latency: a write accepted at edge E is visible on rd_do, with rd_empty=0, in the cycle after E.
  - Cut-through: applies to every word.
  - Store-and-forward: the whole frame becomes readable after the edge accepting its EOF word.
- rd_do shows the next entry in the cycle after a read edge, or rd_empty rises. No bubble for back-to-back reads.
- All status outputs are registered and reflect state after the most recent edge.
- Pulses (wr_err, wr_drop, rd_err) are high for exactly the cycle after the causing edge.
- Full/wrap: wr_full = (wr_ptr[C_ADDR_W] != rd_ptr[C_ADDR_W]) & equal low bits. Pointers wrap modulo 2^(C_ADDR_W+1).
- A frame longer than DEPTH in store-and-forward mode is always discarded at its EOF; the block never deadlocks.

## Test plan
- Defaults, C_STORE_FWD=0: write 0x0..0x4 with EOF on the last word, reading concurrently → rd_do sequence 0..4, each 1 cycle after its write; rd_frames goes 0→1→0.
- C_STORE_FWD=1: write 4 words, EOF on word 4, rd_en held high → rd_empty stays 1 until the cycle after the EOF edge; rd_count jumps 0→4; rd_eof_rdy=1.
- C_STORE_FWD=1: commit frame A (3 words), write 2 words of B, pulse wr_abort → wr_drop pulses once; wr_count returns to 3; reading yields only A.
- C_ADDR_W=4: fill 16 words without EOF, then write a 17th → wr_full=1, wr_err pulses. Store-and-forward: the EOF write also fails, then the next EOF is dropped with wr_drop and wr_count=0.
- Wrap: 40 frames of 3 words streamed through C_ADDR_W=4 → data intact, rd_frames never exceeds 5, EOF read on the same cycle as an EOF write leaves rd_frames unchanged.
- rd_en on empty → rd_err pulse, no pointer change. Assert rst mid-frame → all outputs at reset values next cycle.
